// File: rtl/decode_hazard_stage.sv
// MIPS decode stage and ID/EX register: load-latency scoreboard, EX valid/ready hold, flush.
// Optional writeback-to-decode operand bypass enabled by defining DECODE_WB_BYPASS_EN.
module decode_hazard_stage #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 24,
  parameter int LOAD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_id_valid,
  input  logic [31:0]       if_id_instrucao,
  input  logic [DATA_W-1:0] if_id_proximopc,
  input  logic [CTRL_W-1:0] ctl_bundle,
  input  logic [4:0]        ctl_regdest,
  input  logic              ctl_writereg,
  input  logic              ctl_isload,
  input  logic              ctl_usesrs,
  input  logic              ctl_usesrt,
  input  logic [DATA_W-1:0] reg_id_dataa,
  input  logic [DATA_W-1:0] reg_id_datab,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  input  logic              ex_flush,
  output logic [4:0]        id_reg_addra,
  output logic [4:0]        id_reg_addrb,
  output logic              id_if_stall,
  output logic [DATA_W-1:0] id_if_pcimd2ext,
  output logic              id_ex_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic [DATA_W-1:0] id_ex_rega,
  output logic [DATA_W-1:0] id_ex_regb,
  output logic [DATA_W-1:0] id_ex_imedext,
  output logic [DATA_W-1:0] id_ex_proximopc,
  output logic [4:0]        id_ex_regdest,
  output logic              id_ex_writereg,
  output logic [1:0]        id_state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HAZ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  state_t state_q, state_d;

  logic [4:0]               rs, rt;
  logic signed [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0]        opa, opb;
  logic                     hazard, issue, sb_new_v, stall;

  logic [LOAD_LAT-1:0]      sb_v;
  logic [4:0]               sb_dest [LOAD_LAT];

  logic                     vld_p1, writereg_p1;
  logic [CTRL_W-1:0]        ctrl_p1;
  logic [4:0]               regdest_p1;
  logic [DATA_W-1:0]        rega_p1, regb_p1, proximopc_p1;
  logic signed [DATA_W-1:0] imedext_p1;

  assign rs           = if_id_instrucao[25:21];
  assign rt           = if_id_instrucao[20:16];
  assign imm_ext      = sext16(if_id_instrucao[15:0]);
  assign id_reg_addra = rs;
  assign id_reg_addrb = rt;

  // Branch target wraps modulo 2^DATA_W.
  assign id_if_pcimd2ext = if_id_proximopc + {imm_ext[DATA_W-3:0], 2'b00};

`ifdef DECODE_WB_BYPASS_EN
  assign opa = (wb_we && (wb_addr != 5'd0) && (wb_addr == rs)) ? wb_data : reg_id_dataa;
  assign opb = (wb_we && (wb_addr != 5'd0) && (wb_addr == rt)) ? wb_data : reg_id_datab;
  logic [5:0] unused_opcode;
  assign unused_opcode = if_id_instrucao[31:26];
`else
  assign opa = reg_id_dataa;
  assign opb = reg_id_datab;
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data, if_id_instrucao[31:26]};
`endif

  // Any in-flight load whose destination is read by the instruction in ID blocks it.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (sb_v[k] && (sb_dest[k] != 5'd0)) begin
        if ((ctl_usesrs && (rs == sb_dest[k])) || (ctl_usesrt && (rt == sb_dest[k])))
          hazard = 1'b1;
      end
    end
    hazard = hazard & if_id_valid;
  end

  assign issue    = if_id_valid & ~hazard & ex_ready & ~ex_flush;
  assign sb_new_v = issue & ctl_isload & ctl_writereg & (ctl_regdest != 5'd0);

  always_comb begin
    state_d = ST_RUN;
    stall   = 1'b0;
    if (ex_flush) begin
      state_d = ST_RUN;
    end else if (!ex_ready) begin
      state_d = ST_HOLD;
      stall   = 1'b1;
    end else if (hazard) begin
      state_d = ST_HAZ;
      stall   = 1'b1;
    end
    if (reset) stall = 1'b0;
  end

  assign id_if_stall = stall;
  assign id_state    = state_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Scoreboard advances only when EX accepts; the oldest entry falls off the end.
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_v <= '0;
    end else if (ex_ready) begin
      sb_v[0] <= sb_new_v;
      for (int k = 1; k < LOAD_LAT; k++) sb_v[k] <= sb_v[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (ex_ready) begin
      sb_dest[0] <= ctl_regdest;
      for (int k = 1; k < LOAD_LAT; k++) sb_dest[k] <= sb_dest[k-1];
    end
  end

  // ---- ID -> EX boundary (p1) ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      ctrl_p1      <= '0;
      regdest_p1   <= '0;
      writereg_p1  <= 1'b0;
      rega_p1      <= '0;
      regb_p1      <= '0;
      imedext_p1   <= '0;
      proximopc_p1 <= '0;
    end else if (issue) begin
      vld_p1       <= 1'b1;
      ctrl_p1      <= ctl_bundle;
      regdest_p1   <= ctl_regdest;
      writereg_p1  <= ctl_writereg;
      rega_p1      <= opa;
      regb_p1      <= opb;
      imedext_p1   <= imm_ext;
      proximopc_p1 <= if_id_proximopc;
    end else if (ex_flush || ex_ready) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= '0;
      regdest_p1  <= '0;
      writereg_p1 <= 1'b0;
    end
  end

  assign id_ex_valid     = vld_p1;
  assign id_ex_ctrl      = ctrl_p1;
  assign id_ex_rega      = rega_p1;
  assign id_ex_regb      = regb_p1;
  assign id_ex_imedext   = imedext_p1;
  assign id_ex_proximopc = proximopc_p1;
  assign id_ex_regdest   = regdest_p1;
  assign id_ex_writereg  = writereg_p1;

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Scoreboard bench for decode_hazard_stage; instance 0 uses LOAD_LAT=1, instance 1 uses LOAD_LAT=3.
module tb_decode_hazard_stage;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst, v;
    logic [31:0] instr;
    logic [23:0] ctrl;
    logic [4:0]  dest;
    logic        wr, ld, urs, urt, rdy, flush;
    logic [31:0] pc, da, db;
    logic        wbwe;
    logic [4:0]  wbaddr;
    logic [31:0] wbdata;
  } stim_t;

  typedef struct {
    logic        stall, v;
    logic [23:0] ctrl;
    logic [1:0]  st;
    logic        chk;
    logic [31:0] rega, regb, imm, pc;
    logic [31:0] tgt;
    logic [9:0]  addr;
  } exp_t;

  logic        clock;
  logic        reset, if_id_valid, ctl_writereg, ctl_isload, ctl_usesrs, ctl_usesrt;
  logic [31:0] if_id_instrucao, if_id_proximopc, reg_id_dataa, reg_id_datab, wb_data;
  logic [23:0] ctl_bundle;
  logic [4:0]  ctl_regdest, wb_addr;
  logic        wb_we, ex_ready, ex_flush;

  logic        o_stall [2];
  logic        o_v     [2];
  logic        o_wr    [2];
  logic [23:0] o_ctrl  [2];
  logic [1:0]  o_st    [2];
  logic [4:0]  o_adra  [2];
  logic [4:0]  o_adrb  [2];
  logic [4:0]  o_dest  [2];
  logic [31:0] o_rega  [2];
  logic [31:0] o_regb  [2];
  logic [31:0] o_imm   [2];
  logic [31:0] o_pc    [2];
  logic [31:0] o_tgt   [2];

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  decode_hazard_stage #(.DATA_W(32), .CTRL_W(24), .LOAD_LAT(1)) u_l1 (
    .clock(clock), .reset(reset), .if_id_valid(if_id_valid), .if_id_instrucao(if_id_instrucao),
    .if_id_proximopc(if_id_proximopc), .ctl_bundle(ctl_bundle), .ctl_regdest(ctl_regdest),
    .ctl_writereg(ctl_writereg), .ctl_isload(ctl_isload), .ctl_usesrs(ctl_usesrs),
    .ctl_usesrt(ctl_usesrt), .reg_id_dataa(reg_id_dataa), .reg_id_datab(reg_id_datab),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready), .ex_flush(ex_flush),
    .id_reg_addra(o_adra[0]), .id_reg_addrb(o_adrb[0]), .id_if_stall(o_stall[0]),
    .id_if_pcimd2ext(o_tgt[0]), .id_ex_valid(o_v[0]), .id_ex_ctrl(o_ctrl[0]),
    .id_ex_rega(o_rega[0]), .id_ex_regb(o_regb[0]), .id_ex_imedext(o_imm[0]),
    .id_ex_proximopc(o_pc[0]), .id_ex_regdest(o_dest[0]), .id_ex_writereg(o_wr[0]),
    .id_state(o_st[0])
  );

  decode_hazard_stage #(.DATA_W(32), .CTRL_W(24), .LOAD_LAT(3)) u_l3 (
    .clock(clock), .reset(reset), .if_id_valid(if_id_valid), .if_id_instrucao(if_id_instrucao),
    .if_id_proximopc(if_id_proximopc), .ctl_bundle(ctl_bundle), .ctl_regdest(ctl_regdest),
    .ctl_writereg(ctl_writereg), .ctl_isload(ctl_isload), .ctl_usesrs(ctl_usesrs),
    .ctl_usesrt(ctl_usesrt), .reg_id_dataa(reg_id_dataa), .reg_id_datab(reg_id_datab),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready), .ex_flush(ex_flush),
    .id_reg_addra(o_adra[1]), .id_reg_addrb(o_adrb[1]), .id_if_stall(o_stall[1]),
    .id_if_pcimd2ext(o_tgt[1]), .id_ex_valid(o_v[1]), .id_ex_ctrl(o_ctrl[1]),
    .id_ex_rega(o_rega[1]), .id_ex_regb(o_regb[1]), .id_ex_imedext(o_imm[1]),
    .id_ex_proximopc(o_pc[1]), .id_ex_regdest(o_dest[1]), .id_ex_writereg(o_wr[1]),
    .id_state(o_st[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic stim_t idle_s();
    stim_t s;
    s = '{default: '0};
    s.rdy = 1'b1;
    return s;
  endfunction

  function automatic stim_t rst_s();
    stim_t s;
    s = idle_s();
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t lw_s(input logic [23:0] tag, input logic [4:0] rs, input logic [4:0] rt);
    stim_t s;
    s = idle_s();
    s.v = 1'b1; s.instr = {6'h23, rs, rt, 16'h0004}; s.ctrl = tag;
    s.dest = rt; s.wr = 1'b1; s.ld = 1'b1; s.urs = 1'b1;
    return s;
  endfunction

  function automatic stim_t add_s(input logic [23:0] tag, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd);
    stim_t s;
    s = idle_s();
    s.v = 1'b1; s.instr = {6'h00, rs, rt, rd, 5'd0, 6'h20}; s.ctrl = tag;
    s.dest = rd; s.wr = 1'b1; s.urs = 1'b1; s.urt = 1'b1;
    return s;
  endfunction

  function automatic stim_t br_s(input logic [23:0] tag, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [15:0] imm, input logic [31:0] pc);
    stim_t s;
    s = idle_s();
    s.v = 1'b1; s.instr = {6'h04, rs, rt, imm}; s.ctrl = tag; s.pc = pc;
    s.urs = 1'b1; s.urt = 1'b1;
    return s;
  endfunction

  function automatic exp_t ex(input logic stall, input logic v, input logic [23:0] ctrl,
                              input logic [1:0] st);
    exp_t e;
    e = '{default: '0};
    e.stall = stall; e.v = v; e.ctrl = ctrl; e.st = st;
    return e;
  endfunction

  function automatic exp_t exd(input exp_t e0, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    e = e0;
    e.chk = 1'b1; e.rega = a; e.regb = b; e.imm = imm; e.pc = pc;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst; if_id_valid = s.v; if_id_instrucao = s.instr; if_id_proximopc = s.pc;
    ctl_bundle = s.ctrl; ctl_regdest = s.dest; ctl_writereg = s.wr; ctl_isload = s.ld;
    ctl_usesrs = s.urs; ctl_usesrt = s.urt; reg_id_dataa = s.da; reg_id_datab = s.db;
    wb_we = s.wbwe; wb_addr = s.wbaddr; wb_data = s.wbdata;
    ex_ready = s.rdy; ex_flush = s.flush;
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    stim_t t;
    t = add_s(24'h000100, 5'd3, 5'd4, 5'd6); t.rst = 1'b1; t.da = 32'h55; t.pc = 32'h40;
    s.push_back(t);                                   e.push_back(exd(ex(0, 0, 0, 0), 0, 0, 0, 0));
    s.push_back(lw_s(24'h000101, 5'd1, 5'd5));        e.push_back(ex(0, 1, 24'h000101, 0));
    t = add_s(24'h000102, 5'd5, 5'd7, 5'd6); t.rst = 1'b1;
    s.push_back(t);                                   e.push_back(exd(ex(0, 0, 0, 0), 0, 0, 0, 0));
    s.push_back(add_s(24'h000102, 5'd5, 5'd7, 5'd6)); e.push_back(ex(0, 1, 24'h000102, 0));
    foreach (s[i]) begin
      @(negedge clock); apply(s[i]); exp_q.push_back(e[i]); #1;
      n_cmp++;
      if (o_stall[0] !== e[i].stall) begin
        n_fail++;
        $display("FAIL reset stall cyc%0d: got %b want %b", i, o_stall[0], e[i].stall);
      end
      @(posedge clock); #1; x = exp_q.pop_front();
      n_cmp++;
      if ({o_v[0], o_st[0], o_ctrl[0]} !== {x.v, x.st, x.ctrl}) begin
        n_fail++;
        $display("FAIL reset idex cyc%0d: got v=%b st=%0d ctrl=%h want v=%b st=%0d ctrl=%h",
                 i, o_v[0], o_st[0], o_ctrl[0], x.v, x.st, x.ctrl);
      end
      if (x.chk) begin
        n_cmp++;
        if ({o_rega[0], o_regb[0], o_imm[0], o_pc[0], o_dest[0], o_wr[0]} !==
            {x.rega, x.regb, x.imm, x.pc, 5'd0, 1'b0}) begin
          n_fail++;
          $display("FAIL reset data cyc%0d: got a=%h b=%h imm=%h pc=%h dest=%0d wr=%b want zeros",
                   i, o_rega[0], o_regb[0], o_imm[0], o_pc[0], o_dest[0], o_wr[0]);
        end
      end
    end
  endtask

  task automatic test_load_use_l1();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    s.push_back(rst_s());                             e.push_back(ex(0, 0, 0, 0));
    s.push_back(lw_s(24'h000201, 5'd1, 5'd5));        e.push_back(ex(0, 1, 24'h000201, 0));
    s.push_back(add_s(24'h000202, 5'd5, 5'd7, 5'd6)); e.push_back(ex(1, 0, 0, 1));
    s.push_back(add_s(24'h000202, 5'd5, 5'd7, 5'd6)); e.push_back(ex(0, 1, 24'h000202, 0));
    s.push_back(idle_s());                            e.push_back(ex(0, 0, 0, 0));
    foreach (s[i]) begin
      @(negedge clock); apply(s[i]); exp_q.push_back(e[i]); #1;
      n_cmp++;
      if (o_stall[0] !== e[i].stall) begin
        n_fail++;
        $display("FAIL load_use_l1 stall cyc%0d: got %b want %b", i, o_stall[0], e[i].stall);
      end
      @(posedge clock); #1; x = exp_q.pop_front();
      n_cmp++;
      if ({o_v[0], o_st[0], o_ctrl[0]} !== {x.v, x.st, x.ctrl}) begin
        n_fail++;
        $display("FAIL load_use_l1 idex cyc%0d: got v=%b st=%0d ctrl=%h want v=%b st=%0d ctrl=%h",
                 i, o_v[0], o_st[0], o_ctrl[0], x.v, x.st, x.ctrl);
      end
    end
  endtask

  task automatic test_load_use_l3();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    stim_t t;
    s.push_back(rst_s());                             e.push_back(ex(0, 0, 0, 0));
    s.push_back(lw_s(24'h000301, 5'd2, 5'd8));        e.push_back(ex(0, 1, 24'h000301, 0));
    s.push_back(add_s(24'h000302, 5'd1, 5'd2, 5'd9)); e.push_back(ex(0, 1, 24'h000302, 0));
    s.push_back(add_s(24'h000303, 5'd8, 5'd3, 5'd10)); e.push_back(ex(1, 0, 0, 1));
    s.push_back(add_s(24'h000303, 5'd8, 5'd3, 5'd10)); e.push_back(ex(1, 0, 0, 1));
    s.push_back(add_s(24'h000303, 5'd8, 5'd3, 5'd10)); e.push_back(ex(0, 1, 24'h000303, 0));
    t = lw_s(24'h000304, 5'd2, 5'd0);
    s.push_back(t);                                   e.push_back(ex(0, 1, 24'h000304, 0));
    s.push_back(add_s(24'h000305, 5'd0, 5'd0, 5'd11)); e.push_back(ex(0, 1, 24'h000305, 0));
    foreach (s[i]) begin
      @(negedge clock); apply(s[i]); exp_q.push_back(e[i]); #1;
      n_cmp++;
      if (o_stall[1] !== e[i].stall) begin
        n_fail++;
        $display("FAIL load_use_l3 stall cyc%0d: got %b want %b", i, o_stall[1], e[i].stall);
      end
      @(posedge clock); #1; x = exp_q.pop_front();
      n_cmp++;
      if ({o_v[1], o_st[1], o_ctrl[1]} !== {x.v, x.st, x.ctrl}) begin
        n_fail++;
        $display("FAIL load_use_l3 idex cyc%0d: got v=%b st=%0d ctrl=%h want v=%b st=%0d ctrl=%h",
                 i, o_v[1], o_st[1], o_ctrl[1], x.v, x.st, x.ctrl);
      end
    end
  endtask

  task automatic test_hold();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    stim_t t;
    exp_t  lw_held;
    s.push_back(rst_s()); e.push_back(ex(0, 0, 0, 0));
    t = lw_s(24'h000401, 5'd2, 5'd8);
    t.da = 32'h12345678; t.db = 32'h9; t.pc = 32'h2000; t.instr[15:0] = 16'h0010;
    s.push_back(t);
    lw_held = exd(ex(0, 1, 24'h000401, 0), 32'h12345678, 32'h9, 32'h10, 32'h2000);
    e.push_back(lw_held);
    for (int k = 0; k < 4; k++) begin
      t = add_s(24'h000402, 5'd8, 5'd3, 5'd10); t.rdy = 1'b0; t.da = 32'hFFFF; t.pc = 32'h2004;
      s.push_back(t);
      x = lw_held; x.stall = 1'b1; x.st = 2'd2;
      e.push_back(x);
    end
    for (int k = 0; k < 3; k++) begin
      s.push_back(add_s(24'h000402, 5'd8, 5'd3, 5'd10)); e.push_back(ex(1, 0, 0, 1));
    end
    s.push_back(add_s(24'h000402, 5'd8, 5'd3, 5'd10)); e.push_back(ex(0, 1, 24'h000402, 0));
    foreach (s[i]) begin
      @(negedge clock); apply(s[i]); exp_q.push_back(e[i]); #1;
      n_cmp++;
      if (o_stall[1] !== e[i].stall) begin
        n_fail++;
        $display("FAIL hold stall cyc%0d: got %b want %b", i, o_stall[1], e[i].stall);
      end
      @(posedge clock); #1; x = exp_q.pop_front();
      n_cmp++;
      if ({o_v[1], o_st[1], o_ctrl[1]} !== {x.v, x.st, x.ctrl}) begin
        n_fail++;
        $display("FAIL hold idex cyc%0d: got v=%b st=%0d ctrl=%h want v=%b st=%0d ctrl=%h",
                 i, o_v[1], o_st[1], o_ctrl[1], x.v, x.st, x.ctrl);
      end
      if (x.chk) begin
        n_cmp++;
        if ({o_rega[1], o_regb[1], o_imm[1], o_pc[1]} !== {x.rega, x.regb, x.imm, x.pc}) begin
          n_fail++;
          $display("FAIL hold data cyc%0d: got a=%h b=%h imm=%h pc=%h want a=%h b=%h imm=%h pc=%h",
                   i, o_rega[1], o_regb[1], o_imm[1], o_pc[1], x.rega, x.regb, x.imm, x.pc);
        end
      end
    end
  endtask

  task automatic test_flush();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    stim_t t;
    s.push_back(rst_s());                             e.push_back(ex(0, 0, 0, 0));
    s.push_back(lw_s(24'h000501, 5'd1, 5'd5));        e.push_back(ex(0, 1, 24'h000501, 0));
    t = add_s(24'h000502, 5'd5, 5'd7, 5'd6); t.flush = 1'b1;
    s.push_back(t);                                   e.push_back(ex(0, 0, 0, 0));
    s.push_back(add_s(24'h000502, 5'd5, 5'd7, 5'd6)); e.push_back(ex(0, 1, 24'h000502, 0));
    s.push_back(lw_s(24'h000503, 5'd1, 5'd5));        e.push_back(ex(0, 1, 24'h000503, 0));
    t = add_s(24'h000504, 5'd7, 5'd5, 5'd6); t.flush = 1'b1; t.rdy = 1'b0;
    s.push_back(t);                                   e.push_back(ex(0, 0, 0, 0));
    s.push_back(add_s(24'h000504, 5'd7, 5'd5, 5'd6)); e.push_back(ex(1, 0, 0, 1));
    s.push_back(add_s(24'h000504, 5'd7, 5'd5, 5'd6)); e.push_back(ex(0, 1, 24'h000504, 0));
    foreach (s[i]) begin
      @(negedge clock); apply(s[i]); exp_q.push_back(e[i]); #1;
      n_cmp++;
      if (o_stall[0] !== e[i].stall) begin
        n_fail++;
        $display("FAIL flush stall cyc%0d: got %b want %b", i, o_stall[0], e[i].stall);
      end
      @(posedge clock); #1; x = exp_q.pop_front();
      n_cmp++;
      if ({o_v[0], o_st[0], o_ctrl[0]} !== {x.v, x.st, x.ctrl}) begin
        n_fail++;
        $display("FAIL flush idex cyc%0d: got v=%b st=%0d ctrl=%h want v=%b st=%0d ctrl=%h",
                 i, o_v[0], o_st[0], o_ctrl[0], x.v, x.st, x.ctrl);
      end
    end
  endtask

  task automatic test_branch_bypass();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    stim_t t;
    s.push_back(rst_s()); x = ex(0, 0, 0, 0); x.tgt = 32'h4; e.push_back(x);
    t = br_s(24'h000601, 5'd9, 5'd4, 16'hFFFF, 32'h00400010);
    t.da = 32'h0; t.db = 32'h22222222; t.wbwe = 1'b1; t.wbaddr = 5'd9; t.wbdata = 32'hDEADBEEF;
    s.push_back(t);
    x = exd(ex(0, 1, 24'h000601, 0), BYP ? 32'hDEADBEEF : 32'h0, 32'h22222222, 32'hFFFFFFFF,
            32'h00400010);
    x.tgt = 32'h0040000C; x.addr = {5'd9, 5'd4}; e.push_back(x);
    t = br_s(24'h000602, 5'd4, 5'd9, 16'h0002, 32'hFFFFFFFC);
    t.da = 32'h33; t.db = 32'h0; t.wbwe = 1'b1; t.wbaddr = 5'd9; t.wbdata = 32'hCAFEF00D;
    s.push_back(t);
    x = exd(ex(0, 1, 24'h000602, 0), 32'h33, BYP ? 32'hCAFEF00D : 32'h0, 32'h2, 32'hFFFFFFFC);
    x.tgt = 32'h00000004; x.addr = {5'd4, 5'd9}; e.push_back(x);
    t = br_s(24'h000603, 5'd0, 5'd0, 16'h7FFC, 32'h00001000);
    t.da = 32'h44; t.db = 32'h55; t.wbwe = 1'b1; t.wbaddr = 5'd0; t.wbdata = 32'hBAD0BAD0;
    s.push_back(t);
    x = exd(ex(0, 1, 24'h000603, 0), 32'h44, 32'h55, 32'h00007FFC, 32'h00001000);
    x.tgt = 32'h00020FF0; x.addr = 10'd0; e.push_back(x);
    foreach (s[i]) begin
      @(negedge clock); apply(s[i]); exp_q.push_back(e[i]); #1;
      n_cmp++;
      if (o_stall[0] !== e[i].stall) begin
        n_fail++;
        $display("FAIL branch stall cyc%0d: got %b want %b", i, o_stall[0], e[i].stall);
      end
      if (e[i].chk) begin
        n_cmp++;
        if ({o_tgt[0], o_adra[0], o_adrb[0]} !== {e[i].tgt, e[i].addr}) begin
          n_fail++;
          $display("FAIL branch target cyc%0d: got tgt=%h ra=%0d rb=%0d want tgt=%h ra=%0d rb=%0d",
                   i, o_tgt[0], o_adra[0], o_adrb[0], e[i].tgt, e[i].addr[9:5], e[i].addr[4:0]);
        end
      end
      @(posedge clock); #1; x = exp_q.pop_front();
      n_cmp++;
      if ({o_v[0], o_st[0], o_ctrl[0]} !== {x.v, x.st, x.ctrl}) begin
        n_fail++;
        $display("FAIL branch idex cyc%0d: got v=%b st=%0d ctrl=%h want v=%b st=%0d ctrl=%h",
                 i, o_v[0], o_st[0], o_ctrl[0], x.v, x.st, x.ctrl);
      end
      if (x.chk) begin
        n_cmp++;
        if ({o_rega[0], o_regb[0], o_imm[0], o_pc[0]} !== {x.rega, x.regb, x.imm, x.pc}) begin
          n_fail++;
          $display("FAIL operand cyc%0d: got a=%h b=%h imm=%h pc=%h want a=%h b=%h imm=%h pc=%h",
                   i, o_rega[0], o_regb[0], o_imm[0], o_pc[0], x.rega, x.regb, x.imm, x.pc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use_l1();
    test_load_use_l3();
    test_hold();
    test_flush();
    test_branch_bypass();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
